saus_vector_loader: RTL and testbench

Upstream stage of the SAUS input-selection path. It collects residual samples arriving as a narrow valid/ready stream, `LANES` samples per beat, into a 32-entry vector. Positions at and above the block size are zero-filled. It then presents the full vector with its size tag, via valid/ready, to the t2s permutation stage. Two vector buffers, used ping-pong, let the next block fill while the previous one waits for downstream.

---
 rtl/saus_vector_loader.sv | 110 +++++++++++
 tb/tb_saus_vector_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/saus_vector_loader.sv
// Collects LANES-wide sample beats into a zero-padded 32-entry vector and hands it downstream.
// Define SAUS_LOADER_PINGPONG_EN for two ping-pong buffers; otherwise a single buffer is used.
module saus_vector_loader #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [LANES-1:0][WIDTH-1:0] in_data,
    input  logic        [1:0]                  in_size,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [31:0][WIDTH-1:0]      out_vector,
    output logic        [1:0]                  out_size,
    output logic        [15:0]                 blocks_done
);

`ifdef SAUS_LOADER_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} buf_state_t;

    buf_state_t           state      [2];
    buf_state_t           state_next [2];
    logic [31:0][WIDTH-1:0] buf_data [2];
    logic [1:0]           buf_size   [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [4:0]           beat_cnt;
    logic                 accept;
    logic                 handshake;
    logic                 first_beat;
    logic                 last_beat;
    logic [1:0]           size_eff;
    logic [5:0]           beats;
    logic [4:0]           base;

    assign in_ready   = (state[wr_ptr] != FULL);
    assign out_valid  = (state[rd_ptr] == FULL);
    assign out_vector = buf_data[rd_ptr];
    assign out_size   = buf_size[rd_ptr];
    assign accept     = in_valid && in_ready;
    assign handshake  = out_valid && out_ready;
    assign first_beat = (beat_cnt == 5'd0);

    // The block length is only known from in_size on the first beat; later beats use the latched code.
    assign size_eff  = first_beat ? in_size : buf_size[wr_ptr];
    assign beats     = 6'((32'd4 << size_eff) / LANES);
    assign last_beat = ({1'b0, beat_cnt} == beats - 6'd1);
    assign base      = 5'(int'(beat_cnt) * LANES);

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_next[b] = state[b];
            if (accept && wr_ptr == 1'(b))
                state_next[b] = last_beat ? FULL : FILLING;
            if (handshake && rd_ptr == 1'(b))
                state_next[b] = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                state[b] <= EMPTY;
        end else begin
            for (int b = 0; b < 2; b++)
                state[b] <= state_next[b];
        end
    end

    // The whole-buffer clear on the first beat is overridden element-wise by the lane writes below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                buf_data[b] <= '0;
                buf_size[b] <= '0;
            end
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            beat_cnt    <= '0;
            blocks_done <= '0;
        end else begin
            if (accept) begin
                if (first_beat) begin
                    buf_data[wr_ptr] <= '0;
                    buf_size[wr_ptr] <= in_size;
                end
                for (int k = 0; k < LANES; k++)
                    buf_data[wr_ptr][base + 5'(k)] <= in_data[k];
                if (last_beat) begin
                    beat_cnt <= '0;
                    wr_ptr   <= wr_ptr ^ PP;
                end else begin
                    beat_cnt <= beat_cnt + 5'd1;
                end
            end
            if (handshake) begin
                rd_ptr      <= rd_ptr ^ PP;
                blocks_done <= blocks_done + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_saus_vector_loader.sv
// Randomized self-checking bench for saus_vector_loader against a queue-based block model.
module tb_saus_vector_loader;

    localparam int WIDTH = 16;
    localparam int LANES = 4;
`ifdef SAUS_LOADER_PINGPONG_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif

    typedef logic [31:0][WIDTH-1:0] vec_t;
    typedef struct {
        vec_t       vec;
        logic [1:0] size;
    } blk_t;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               in_valid;
    logic                               in_ready;
    logic signed [LANES-1:0][WIDTH-1:0] in_data;
    logic        [1:0]                  in_size;
    logic                               out_valid;
    logic                               out_ready;
    logic signed [31:0][WIDTH-1:0]      out_vector;
    logic        [1:0]                  out_size;
    logic        [15:0]                 blocks_done;

    saus_vector_loader #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_size     (in_size),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vector  (out_vector),
        .out_size    (out_size),
        .blocks_done (blocks_done)
    );

    always #5 clk = ~clk;

    // Reference model: completed blocks waiting downstream, plus the block currently being filled.
    blk_t       exp_q[$];
    vec_t       cur_vec;
    logic [1:0] cur_size;
    int         cur_beat;
    int         exp_done;
    int         checks;
    int         passed;

    task automatic checkOutput(input string tag, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic checkState();
        checkOutput("in_ready", 512'(in_ready), 512'(exp_q.size() < NBUF));
        checkOutput("out_valid", 512'(out_valid), 512'(exp_q.size() > 0));
        checkOutput("blocks_done", 512'(blocks_done), 512'(16'(exp_done)));
        if (exp_q.size() > 0) begin
            checkOutput("out_vector", 512'(out_vector), 512'(exp_q[0].vec));
            checkOutput("out_size", 512'(out_size), 512'(exp_q[0].size));
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [LANES-1:0][WIDTH-1:0] d,
                                 input logic [1:0] s, input logic r);
        logic acc;
        logic hs;
        in_valid  = v;
        in_data   = d;
        in_size   = s;
        out_ready = r;
        #1;
        checkState();
        acc = v && (exp_q.size() < NBUF);
        hs  = r && (exp_q.size() > 0);
        @(posedge clk);
        if (hs) begin
            exp_q.delete(0);
            exp_done++;
        end
        if (acc) begin
            if (cur_beat == 0) begin
                cur_vec  = '0;
                cur_size = s;
            end
            for (int k = 0; k < LANES; k++)
                cur_vec[cur_beat * LANES + k] = d[k];
            cur_beat++;
            if (cur_beat == (4 << cur_size) / LANES) begin
                exp_q.push_back('{cur_vec, cur_size});
                cur_beat = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic sendBlock(input logic [1:0] size, input int first, input int step, input logic r);
        logic [LANES-1:0][WIDTH-1:0] d;
        logic [1:0] s;
        for (int j = 0; j < (4 << size) / LANES; j++) begin
            for (int k = 0; k < LANES; k++)
                d[k] = WIDTH'(first + step * (j * LANES + k));
            s = (j == 0) ? size : 2'($urandom);
            applyStimulus(1'b1, d, s, r);
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, 2'd0, r);
    endtask

    task automatic doReset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("rst_in_ready", 512'(in_ready), 512'(1'b1));
        checkOutput("rst_out_valid", 512'(out_valid), 512'(1'b0));
        checkOutput("rst_out_vector", 512'(out_vector), 512'(0));
        checkOutput("rst_out_size", 512'(out_size), 512'(2'd0));
        checkOutput("rst_blocks_done", 512'(blocks_done), 512'(16'd0));
        exp_q.delete();
        cur_beat = 0;
        exp_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [LANES-1:0][WIDTH-1:0] d;
        checks    = 0;
        passed    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = 2'd0;
        out_ready = 1'b0;
        cur_vec   = '0;
        cur_size  = 2'd0;
        @(negedge clk);
        doReset();

        sendBlock(2'd3, 1, 1, 1'b1);
        idle(3, 1'b1);

        sendBlock(2'd3, -1, 0, 1'b1);
        sendBlock(2'd1, 100, 1, 1'b1);
        idle(4, 1'b1);

        for (int b = 0; b < 3; b++)
            sendBlock(2'd0, 200 + 4 * b, 1, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        sendBlock(2'd2, 300, 1, 1'b0);
        sendBlock(2'd2, 400, 1, 1'b1);
        idle(4, 1'b1);

        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < LANES; k++)
                d[k] = WIDTH'(900 + j * LANES + k);
            applyStimulus(1'b1, d, 2'd3, 1'b1);
        end
        doReset();
        sendBlock(2'd3, 500, 3, 1'b1);
        idle(3, 1'b1);

        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < LANES; k++)
                d[k] = WIDTH'($urandom);
            applyStimulus(1'b1 && ($urandom_range(0, 3) != 0), d, 2'($urandom),
                          ($urandom_range(0, 2) != 0));
        end

        for (int c = 0; c < 200; c++) begin
            for (int k = 0; k < LANES; k++)
                d[k] = WIDTH'($urandom);
            applyStimulus(1'b1, d, 2'd0, 1'b1);
        end
        idle(6, 1'b1);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
